// File: rtl/cflog_pkg.sv
// rtl/cflog_pkg.sv - shared state encodings and write-request codes for the CF-Log FIFO
package cflog_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_ZERO  = 2'd2
  } cflog_state_e;

  localparam logic [1:0] WEN_NONE = 2'b00;
  localparam logic [1:0] WEN_ONE  = 2'b01;
  localparam logic [1:0] WEN_TWO  = 2'b11;

endpackage

// File: rtl/cflog_fifo_if.sv
// rtl/cflog_fifo_if.sv - flush output stream of the CF-Log FIFO
interface cflog_fifo_if #(
  parameter int DATA_W = 16
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/cflog_dpram.sv
// rtl/cflog_dpram.sv - log storage: two write ports, gated random-access read, flush read
module cflog_dpram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk_i,
  input  logic              we_a_i,
  input  logic [ADDR_W-1:0] addr_a_i,
  input  logic [DATA_W-1:0] din_a_i,
  input  logic              we_b_i,
  input  logic [ADDR_W-1:0] addr_b_i,
  input  logic [DATA_W-1:0] din_b_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              rd_cen_i,
  output logic [DATA_W-1:0] rd_dout_o,
  input  logic [ADDR_W-1:0] f_addr_i,
  output logic [DATA_W-1:0] f_dout_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // No reset: contents survive puc_rst by design.
  always_ff @(posedge clk_i) begin
    if (we_a_i) mem_q[addr_a_i] <= din_a_i;
    if (we_b_i) mem_q[addr_b_i] <= din_b_i;
  end

  assign rd_dout_o = rd_cen_i ? '0 : mem_q[rd_addr_i];
  assign f_dout_o  = mem_q[f_addr_i];

endmodule

// File: rtl/cflog_fifo.sv
// rtl/cflog_fifo.sv - CF-Log FIFO with single/dual-entry writes and a flush stream
// Optional CFLOG_ZEROIZE_EN: wipe every entry after each flush.
module cflog_fifo
  import cflog_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7,
  parameter int THRESH = DEPTH - 2
) (
  input  logic              mclk,
  input  logic              puc_rst,
  input  logic [1:0]        log_wen,
  input  logic [DATA_W-1:0] log_din1,
  input  logic [DATA_W-1:0] log_din2,
  output logic [ADDR_W:0]   log_count,
  output logic              log_full,
  output logic              log_thresh,
  output logic              log_drop,
  input  logic              flush_req,
  output logic              flush_busy,
  cflog_fifo_if.master      out_if,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_cen,
  output logic [DATA_W-1:0] rd_dout
);

  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] THRESH_C = (ADDR_W+1)'(THRESH);

  cflog_state_e      state_q;
  logic [ADDR_W:0]   count_q, count_d, free, wr_n;
  logic [ADDR_W-1:0] rd_ptr_q, addr_a, addr_b;
  logic [DATA_W-1:0] din_a;
  logic              drop_q, we_a, we_b, wr_req, wr_drop, is_flush, last;
`ifdef CFLOG_ZEROIZE_EN
  logic [ADDR_W-1:0] zptr_q;
`endif

  assign wr_req   = (log_wen == WEN_ONE) || (log_wen == WEN_TWO);
  assign free     = DEPTH_C - count_q;
  assign is_flush = (state_q == ST_FLUSH);
  assign last     = ({1'b0, rd_ptr_q} == (count_q - 1'b1));
  assign count_d  = count_q + wr_n;

  // A dual write with one slot left keeps din1 and drops din2.
  always_comb begin
    we_a    = 1'b0;
    we_b    = 1'b0;
    addr_a  = count_q[ADDR_W-1:0];
    addr_b  = count_q[ADDR_W-1:0] + ADDR_W'(1);
    din_a   = log_din1;
    wr_n    = '0;
    wr_drop = 1'b0;
    if (wr_req) begin
      if (state_q != ST_IDLE || free == '0) begin
        wr_drop = 1'b1;
      end else begin
        we_a = 1'b1;
        wr_n = (ADDR_W+1)'(1);
        if (log_wen == WEN_TWO) begin
          if (free >= (ADDR_W+1)'(2)) begin
            we_b = 1'b1;
            wr_n = (ADDR_W+1)'(2);
          end else begin
            wr_drop = 1'b1;
          end
        end
      end
    end
`ifdef CFLOG_ZEROIZE_EN
    if (state_q == ST_ZERO) begin
      we_a   = 1'b1;
      addr_a = zptr_q;
      din_a  = '0;
    end
`endif
    if (puc_rst) begin
      we_a = 1'b0;
      we_b = 1'b0;
    end
  end

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      drop_q   <= 1'b0;
`ifdef CFLOG_ZEROIZE_EN
      zptr_q   <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          count_q <= count_d;
          if (flush_req && count_d != '0) begin
            rd_ptr_q <= '0;
            state_q  <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (out_if.out_ready) begin
            rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            if (last) begin
              count_q <= '0;
              drop_q  <= 1'b0;
`ifdef CFLOG_ZEROIZE_EN
              zptr_q  <= '0;
              state_q <= ST_ZERO;
`else
              state_q <= ST_IDLE;
`endif
            end
          end
        end
`ifdef CFLOG_ZEROIZE_EN
        ST_ZERO: begin
          zptr_q <= zptr_q + ADDR_W'(1);
          if (zptr_q == ADDR_W'(DEPTH - 1)) state_q <= ST_IDLE;
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
      // A discard in the same cycle as the final beat is still reported.
      if (wr_drop) drop_q <= 1'b1;
    end
  end

  cflog_dpram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk_i    (mclk),
    .we_a_i   (we_a),
    .addr_a_i (addr_a),
    .din_a_i  (din_a),
    .we_b_i   (we_b),
    .addr_b_i (addr_b),
    .din_b_i  (log_din2),
    .rd_addr_i(rd_addr),
    .rd_cen_i (rd_cen),
    .rd_dout_o(rd_dout),
    .f_addr_i (rd_ptr_q),
    .f_dout_o (out_if.out_data)
  );

  assign log_count        = count_q;
  assign log_full         = (count_q == DEPTH_C);
  assign log_thresh       = (count_q >= THRESH_C);
  assign log_drop         = drop_q;
  assign flush_busy       = (state_q != ST_IDLE);
  assign out_if.out_valid = is_flush;
  assign out_if.out_last  = is_flush && last;

endmodule

// File: doc/cflog_fifo.md
CFLOG_FIFO -- requirements
Module: cflog_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning CF-Log entry width in bits.
REQ-002 SHALL have parameter DEPTH, default 128, meaning number of entries (power of two, >=4).
REQ-003 SHALL have parameter ADDR_W, default 7, meaning log2(DEPTH).
REQ-004 SHALL have parameter THRESH, default DEPTH-2, meaning occupancy at which log_thresh asserts.
REQ-005 SHALL have port mclk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-006 SHALL have port puc_rst, input, 1, meaning reset, synchronous and active-high.
REQ-007 SHALL have port log_wen, input, 2, meaning write request: 01 = one entry (din1); 11 = two entries (din1 then din2); 10 ignored.
REQ-008 SHALL have ports log_din1 and log_din2, input, DATA_W each, meaning the first and second entry data.
REQ-009 SHALL have port log_count, output, ADDR_W+1, meaning current occupancy.
REQ-010 SHALL have ports log_full and log_thresh, output, 1 each, meaning count==DEPTH and count>=THRESH.
REQ-011 SHALL have port log_drop, output, 1, meaning sticky flag: at least one entry was discarded.
REQ-012 SHALL have port flush_req, input, 1, meaning a single-cycle request to stream the log out.
REQ-013 SHALL have port flush_busy, output, 1, meaning the block is not in IDLE.
REQ-014 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, DATA_W) and out_last (output, 1), meaning the flush stream.
REQ-015 SHALL have ports rd_addr (input, ADDR_W), rd_cen (input, 1, active-low) and rd_dout (output, DATA_W), meaning the random-access read port.

Function
REQ-016 SHALL implement the states IDLE, FLUSH and (with the macro) ZERO.
REQ-017 In IDLE, log_wen=01 SHALL write mem[count]<=din1 and increment count by 1, visible the next cycle.
REQ-018 In IDLE, log_wen=11 SHALL write mem[count]<=din1 and mem[count+1]<=din2 and increment count by 2.
REQ-019 If log_wen=11 arrives with exactly one free entry, the block SHALL store din1 only, discard din2 and set log_drop.
REQ-020 Any write arriving when full, or outside IDLE, SHALL be discarded and SHALL set log_drop.
REQ-021 rd_dout SHALL be combinational: mem[rd_addr] when rd_cen=0, else all zeros; it is valid in every state.
REQ-022 flush_req in IDLE with count>0 SHALL clear rd_ptr and enter FLUSH the next cycle; any write in that same cycle SHALL be taken first and included in the flush.
REQ-023 flush_req with count==0, or outside IDLE, SHALL be ignored.
REQ-024 In FLUSH: out_valid=1, out_data=mem[rd_ptr], out_last=(rd_ptr==count-1).
REQ-025 In FLUSH, a beat SHALL occur when out_valid and out_ready are both high, and each beat SHALL increment rd_ptr.
REQ-026 out_valid and out_data SHALL hold stable while out_ready is low.
REQ-027 On the last beat the block SHALL set count<=0 and clear log_drop, then go to IDLE (or to ZERO when the macro is defined).
REQ-028 out_valid, out_last and flush_busy SHALL be 0 in IDLE.
REQ-029 log_full and log_thresh SHALL be decoded from the registered count with no added latency.

Reset
REQ-030 puc_rst high at a clock edge SHALL force IDLE, count=0, rd_ptr=0 and log_drop=0.
REQ-031 During and after reset, out_valid=0, out_last=0, flush_busy=0, log_full=0 and log_thresh=0.
REQ-032 Reset SHALL take priority over writes and flush, including mid-FLUSH and mid-ZERO; memory contents SHALL be left unchanged.

Configuration
REQ-033 With CFLOG_ZEROIZE_EN defined, after the last flush beat the block SHALL enter ZERO and write 0 to one entry per cycle, from index 0 to DEPTH-1, then return to IDLE; flush_busy SHALL stay 1 throughout.
REQ-034 Without CFLOG_ZEROIZE_EN, the ZERO state and its logic SHALL be absent, FLUSH SHALL return directly to IDLE, and stale entries SHALL persist.

Structure
REQ-035 State encodings (IDLE=0, FLUSH=1, ZERO=2) and the log_wen code constants SHALL live in a shared package, cflog_pkg.
REQ-036 Storage SHALL be one sub-module, cflog_dpram: two synchronous write ports, one combinational read port with chip-enable, and a flush read port, inferable as block RAM.

Verification
REQ-037 Reset, then log_wen=11 with din1=0xA001, din2=0xA002 -> next cycle count=2, rd_addr=0/1 read 0xA001/0xA002, rd_cen=1 reads 0x0000.
REQ-038 DEPTH=8, THRESH=6: write 7 entries, then log_wen=11 -> count=8, log_full=1, log_drop=1, mem[7]=din1; log_thresh rises when count reaches 6.
REQ-039 count=3, flush_req, out_ready toggled 1,0,1,1 -> exactly 3 beats in address order, out_last on beat 3 only, out_data stable while stalled, then count=0 and log_drop=0.
REQ-040 Writes and flush_req issued during FLUSH -> writes dropped with log_drop=1, second flush ignored; flush_req with count==0 -> flush_busy stays 0.
REQ-041 puc_rst asserted mid-FLUSH after 1 of 4 beats -> next cycle IDLE, out_valid=0, count=0.
REQ-042 With CFLOG_ZEROIZE_EN, DEPTH=8: flush 2 entries -> flush_busy high for exactly 2+8 cycles with out_ready=1, and all entries read 0 afterwards.
